// File: rtl/tx_iq_framer_pkg.sv
// Shared types and helpers for the transmit I/Q framer.
package tx_framer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 12;
  localparam int UF_CNT_W   = 16;

  // One I slot and one Q slot per channel.
  function automatic int slot_cnt(input int ch_num);
    return 2 * ch_num;
  endfunction

  // Frame marker for slot k: 1T marks only the I slot, 2T marks both ch0 slots.
  function automatic logic frame_bit(input int ch_num, input int k);
    return (ch_num == 1) ? (k == 0) : (k < 2);
  endfunction

endpackage

// File: rtl/tx_iq_framer_sync_fifo.sv
// Single-clock FIFO with show-ahead read data, full/empty flags and fill level.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rd_data = mem[rd_ptr];

  // Storage array, no reset needed: contents are qualified by the count.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_wr && !do_rd) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (!do_wr && do_rd) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tx_iq_framer.sv
// Transmit I/Q framer: per-channel FIFOs feeding a time-interleaved AD9361 TX bus.
// Optional macro TX_FRAMER_PATTERN_EN adds pattern_sel, which replaces FIFO data
// with a per-frame ramp (I = ramp, Q = ~ramp) while streaming.
//
// state | meaning
// IDLE  | outputs zero, no pops, waits for enable
// PRIME | waits until every FIFO holds at least PREFILL entries
// RUN   | emits one frame per 2*CH_NUM cycles, pops all channels together at slot 0
module tx_iq_framer
  import tx_framer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CH_NUM     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PREFILL    = 2
) (
  input  logic                       clk_32d768M,
  input  logic                       rst_32d768M,
`ifdef TX_FRAMER_PATTERN_EN
  input  logic                       pattern_sel,
`endif
  input  logic                       enable,
  input  logic [CH_NUM-1:0]          s_valid,
  output logic [CH_NUM-1:0]          s_ready,
  input  logic [CH_NUM*DATA_W-1:0]   s_i,
  input  logic [CH_NUM*DATA_W-1:0]   s_q,
  output logic [DATA_W-1:0]          tx_d,
  output logic                       tx_frame,
  output logic                       tx_run,
  output logic                       underflow,
  output logic [UF_CNT_W-1:0]        underflow_cnt
);

  localparam int SLOTS = slot_cnt(CH_NUM);
  localparam int KW    = (SLOTS > 2) ? $clog2(SLOTS) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(SLOTS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [KW-1:0]       k;
  logic [KW-1:0]       k_nxt;
  logic                ready_en;
  logic                pop;
  logic                all_ready;
  logic                frame_start;
  logic                uf_evt;
  logic                ramp_step;
  logic                pat_mode;
  logic [CH_NUM-1:0]   full;
  logic [CH_NUM-1:0]   empty;
  logic [CH_NUM-1:0]   wr_en;
  logic [CH_NUM-1:0]   prefilled;
  logic [LW-1:0]       level [CH_NUM];
  logic [2*DATA_W-1:0] head  [CH_NUM];
  logic [DATA_W-1:0]   load_d [SLOTS];
  logic [DATA_W-1:0]   slot_d [SLOTS];
  logic [DATA_W-1:0]   ramp;

`ifdef TX_FRAMER_PATTERN_EN
  assign pat_mode = pattern_sel;
`else
  assign pat_mode = 1'b0;
`endif

  // ready_en holds s_ready low through reset and for the release edge.
  assign s_ready   = {CH_NUM{ready_en}} & ~full;
  assign wr_en     = s_valid & s_ready;
  assign all_ready = ~|empty;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    sync_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk_32d768M),
      .rst     (rst_32d768M),
      .wr_en   (wr_en[c]),
      .wr_data ({s_i[c*DATA_W +: DATA_W], s_q[c*DATA_W +: DATA_W]}),
      .rd_en   (pop),
      .rd_data (head[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .level   (level[c])
    );
    assign prefilled[c] = (level[c] >= LW'(PREFILL));
  end

  // Sequencer state and slot counter.
  always_ff @(posedge clk_32d768M) begin
    if (rst_32d768M) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next state; slot 0 of each RUN frame decides between pop, pattern and underflow.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    pop         = 1'b0;
    uf_evt      = 1'b0;
    ramp_step   = 1'b0;
    frame_start = 1'b0;
    unique case (state)
      IDLE: begin
        k_nxt = '0;
        if (enable) begin
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        k_nxt = '0;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (&prefilled) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (k == '0) begin
          frame_start = 1'b1;
          if (pat_mode) begin
            ramp_step = 1'b1;
          end else if (all_ready) begin
            pop = 1'b1;
          end else begin
            uf_evt = 1'b1;
          end
        end
        if (k == K_LAST) begin
          k_nxt = '0;
          if (!enable) begin
            state_nxt = IDLE;
          end
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // Words captured at frame start: ramp, FIFO heads, or zeros on underflow.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      load_d[s] = '0;
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (pat_mode) begin
        load_d[2*c]   = ramp;
        load_d[2*c+1] = ~ramp;
      end else if (all_ready) begin
        load_d[2*c]   = head[c][2*DATA_W-1 -: DATA_W];
        load_d[2*c+1] = head[c][DATA_W-1:0];
      end
    end
  end

  // Frame registers hold the remaining slots while slot 0 goes straight to the bus.
  always_ff @(posedge clk_32d768M) begin
    if (rst_32d768M) begin
      for (int s = 0; s < SLOTS; s++) begin
        slot_d[s] <= '0;
      end
    end else if (frame_start) begin
      for (int s = 0; s < SLOTS; s++) begin
        slot_d[s] <= load_d[s];
      end
    end
  end

  // Registered output bus.
  always_ff @(posedge clk_32d768M) begin
    if (rst_32d768M) begin
      tx_d     <= '0;
      tx_frame <= 1'b0;
      tx_run   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      tx_run   <= (state == RUN);
      if (state == RUN) begin
        tx_frame <= frame_bit(CH_NUM, int'(k));
        tx_d     <= frame_start ? load_d[0] : slot_d[k];
      end else begin
        tx_frame <= 1'b0;
        tx_d     <= '0;
      end
    end
  end

  // Test ramp and underflow bookkeeping.
  always_ff @(posedge clk_32d768M) begin
    if (rst_32d768M) begin
      ramp          <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      if (ramp_step) begin
        ramp <= ramp + DATA_W'(1);
      end
      if (uf_evt) begin
        underflow <= 1'b1;
        if (underflow_cnt != {UF_CNT_W{1'b1}}) begin
          underflow_cnt <= underflow_cnt + UF_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_iq_framer.sv
// Directed bench for tx_iq_framer: a 1T instance driven from a vector table and
// hand-written sequences, plus a 2T instance for interleave, skew and reset cases.
module tb_tx_iq_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 1T instance
  logic        rst1, en1;
  logic [0:0]  vld1, rdy1;
  logic [11:0] si1, sq1, d1;
  logic        f1, r1, uf1;
  logic [15:0] cnt1;
  // 2T instance
  logic        rst2, en2;
  logic [1:0]  vld2, rdy2;
  logic [23:0] si2, sq2;
  logic [11:0] d2;
  logic        f2, r2, uf2;
  logic [15:0] cnt2;
`ifdef TX_FRAMER_PATTERN_EN
  logic        pat1, pat2;
`endif

  tx_iq_framer #(.DATA_W(12), .CH_NUM(1), .FIFO_DEPTH(8), .PREFILL(2)) dut1 (
    .clk_32d768M (clk), .rst_32d768M (rst1),
`ifdef TX_FRAMER_PATTERN_EN
    .pattern_sel (pat1),
`endif
    .enable (en1), .s_valid (vld1), .s_ready (rdy1), .s_i (si1), .s_q (sq1),
    .tx_d (d1), .tx_frame (f1), .tx_run (r1), .underflow (uf1), .underflow_cnt (cnt1)
  );

  tx_iq_framer #(.DATA_W(12), .CH_NUM(2), .FIFO_DEPTH(8), .PREFILL(2)) dut2 (
    .clk_32d768M (clk), .rst_32d768M (rst2),
`ifdef TX_FRAMER_PATTERN_EN
    .pattern_sel (pat2),
`endif
    .enable (en2), .s_valid (vld2), .s_ready (rdy2), .s_i (si2), .s_q (sq2),
    .tx_d (d2), .tx_frame (f2), .tx_run (r2), .underflow (uf2), .underflow_cnt (cnt2)
  );

  typedef struct {
    logic        rst, en, vld;
    logic [11:0] i, q;
    logic [11:0] d;
    logic        f, r, rdy, uf;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic rst, input logic en, input logic vld,
                              input logic [11:0] i, input logic [11:0] q,
                              input logic [11:0] d, input logic f, input logic r,
                              input logic rdy, input logic uf, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld; v.i = i; v.q = q;
    v.d = d; v.f = f; v.r = r; v.rdy = rdy; v.uf = uf; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_run1(input string name);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (r1 === 1'b1) break;
    end
    cmp(name, r1, 1);
  endtask

  task automatic wait_run2(input string name);
    for (int n = 0; n < 20; n++) begin
      tick();
      if (r2 === 1'b1) break;
    end
    cmp(name, r2, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] e2a [8];
    logic [11:0] e2b [16];
`ifdef TX_FRAMER_PATTERN_EN
    logic [11:0] ep  [10];
    pat1 = 1'b0; pat2 = 1'b0;
`endif
    rst1 = 1'b1; en1 = 1'b0; vld1 = '0; si1 = '0; sq1 = '0;
    rst2 = 1'b1; en2 = 1'b0; vld2 = '0; si2 = '0; sq2 = '0;

    //             rst en vld  i      q      | d      f  r  rdy uf cnt
    tbl[0]  = mk(1, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 12'h123, 12'h456, 12'h000, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 12'h123, 12'h456, 12'h000, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 12'h789, 12'hABC, 12'h000, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 12'h000, 12'h000, 12'h123, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 12'h000, 12'h000, 12'h456, 0, 1, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 12'h000, 12'h000, 12'h789, 1, 1, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 12'h000, 12'h000, 12'hABC, 0, 1, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 1, 12'hA01, 12'hB01, 12'h000, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 1, 12'hA02, 12'hB02, 12'h000, 0, 0, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 12'h000, 12'h000, 12'hA01, 1, 1, 1, 0, 0);
    tbl[15] = mk(0, 1, 0, 12'h000, 12'h000, 12'hB01, 0, 1, 1, 0, 0);
    tbl[16] = mk(0, 1, 0, 12'h000, 12'h000, 12'hA02, 1, 1, 1, 0, 0);
    tbl[17] = mk(0, 1, 0, 12'h000, 12'h000, 12'hB02, 0, 1, 1, 0, 0);
    tbl[18] = mk(0, 1, 1, 12'hA03, 12'hB03, 12'h000, 1, 1, 1, 1, 1);
    tbl[19] = mk(0, 1, 0, 12'h000, 12'h000, 12'h000, 0, 1, 1, 1, 1);
    tbl[20] = mk(0, 1, 0, 12'h000, 12'h000, 12'hA03, 1, 1, 1, 1, 1);
    tbl[21] = mk(0, 0, 0, 12'h000, 12'h000, 12'hB03, 0, 1, 1, 1, 1);
    tbl[22] = mk(0, 0, 0, 12'h000, 12'h000, 12'h000, 0, 0, 1, 1, 1);

    // 1T: basic stream, enable drop, underflow frame and recovery
    for (int v = 0; v < 23; v++) begin
      rst1 = tbl[v].rst; en1 = tbl[v].en; vld1 = tbl[v].vld;
      si1 = tbl[v].i; sq1 = tbl[v].q;
      tick();
      cmp($sformatf("v%0d_tx_d", v),   d1,   tbl[v].d);
      cmp($sformatf("v%0d_frame", v),  f1,   tbl[v].f);
      cmp($sformatf("v%0d_run", v),    r1,   tbl[v].r);
      cmp($sformatf("v%0d_ready", v),  rdy1, tbl[v].rdy);
      cmp($sformatf("v%0d_uf", v),     uf1,  tbl[v].uf);
      cmp($sformatf("v%0d_uf_cnt", v), cnt1, tbl[v].cnt);
    end

    // 1T: fill to depth with enable low, ninth write refused, then drain in order
    vld1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      si1 = 12'h200 + 12'(n); sq1 = 12'h300 + 12'(n);
      tick();
      cmp($sformatf("fill%0d_ready", n), rdy1, (n < 7) ? 1 : 0);
    end
    si1 = 12'h2FF; sq1 = 12'h3FF;
    tick();
    vld1 = 1'b0;
    cmp("fill9_ready", rdy1, 0);
    en1 = 1'b1;
    wait_run1("fill_run_start");
    for (int n = 0; n < 16; n++) begin
      if (n > 0) tick();
      cmp($sformatf("drain%0d_tx_d", n), d1,
          (n % 2 == 0) ? 32'(12'h200 + 12'(n/2)) : 32'(12'h300 + 12'(n/2)));
      cmp($sformatf("drain%0d_frame", n), f1, (n % 2 == 0) ? 1 : 0);
    end
    tick();
    cmp("drain_uf_tx_d", d1, 0);
    cmp("drain_uf_frame", f1, 1);
    cmp("drain_uf_cnt", cnt1, 2);
    en1 = 1'b0;
    tick();
    cmp("drain_last_run", r1, 1);
    tick();
    cmp("drain_idle_run", r1, 0);

`ifdef TX_FRAMER_PATTERN_EN
    // 1T: ramp pattern leaves the FIFO untouched, then FIFO data resumes
    vld1 = 1'b1; si1 = 12'hC01; sq1 = 12'hD01;
    tick();
    si1 = 12'hC02; sq1 = 12'hD02;
    tick();
    vld1 = 1'b0;
    pat1 = 1'b1; en1 = 1'b1;
    ep = '{12'h000, 12'hFFF, 12'h001, 12'hFFE, 12'h002, 12'hFFD,
           12'hC01, 12'hD01, 12'hC02, 12'hD02};
    wait_run1("pat_run_start");
    for (int n = 0; n < 10; n++) begin
      if (n > 0) tick();
      cmp($sformatf("pat%0d_tx_d", n), d1, ep[n]);
      cmp($sformatf("pat%0d_frame", n), f1, (n % 2 == 0) ? 1 : 0);
      if (n == 5) pat1 = 1'b0;
      if (n == 8) en1 = 1'b0;
    end
    tick();
    cmp("pat_idle_run", r1, 0);
    cmp("pat_uf_cnt", cnt1, 2);
`endif

    // 2T: reset release, PRIME waits for the slow channel, interleave, enable drop at slot 1
    tick();
    rst2 = 1'b0;
    tick();
    cmp("ch2_ready_after_rst", rdy2, 2'b11);
    en2 = 1'b1;
    vld2 = 2'b01; si2 = {12'h000, 12'h111}; sq2 = {12'h000, 12'h222};
    tick();
    tick();
    vld2 = 2'b00;
    for (int n = 0; n < 3; n++) begin
      tick();
      cmp($sformatf("ch2_skew_hold%0d", n), r2, 0);
    end
    vld2 = 2'b10; si2 = {12'h333, 12'h000}; sq2 = {12'h444, 12'h000};
    tick();
    tick();
    vld2 = 2'b00;
    e2a = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h111, 12'h222, 12'h333, 12'h444};
    wait_run2("ch2_run_start");
    for (int n = 0; n < 8; n++) begin
      if (n > 0) tick();
      cmp($sformatf("ch2_w%0d_tx_d", n), d2, e2a[n]);
      cmp($sformatf("ch2_w%0d_frame", n), f2, (n % 4 < 2) ? 1 : 0);
      cmp($sformatf("ch2_w%0d_run", n), r2, 1);
      if (n == 4) en2 = 1'b0;
    end
    tick();
    cmp("ch2_stop_tx_d", d2, 0);
    cmp("ch2_stop_run", r2, 0);

    // 2T: ch1 starves on frame 3, ch0 must not advance; ch1 refill realigns frame 4
    vld2 = 2'b11; si2 = {12'h701, 12'h501}; sq2 = {12'h801, 12'h601};
    tick();
    si2 = {12'h702, 12'h502}; sq2 = {12'h802, 12'h602};
    tick();
    vld2 = 2'b01; si2 = {12'h000, 12'h503}; sq2 = {12'h000, 12'h603};
    tick();
    vld2 = 2'b00;
    en2 = 1'b1;
    e2b = '{12'h501, 12'h601, 12'h701, 12'h801, 12'h502, 12'h602, 12'h702, 12'h802,
            12'h000, 12'h000, 12'h000, 12'h000, 12'h503, 12'h603, 12'h703, 12'h803};
    wait_run2("ch2_starve_run_start");
    for (int n = 0; n < 16; n++) begin
      if (n > 0) tick();
      vld2 = 2'b00;
      cmp($sformatf("ch2_s%0d_tx_d", n), d2, e2b[n]);
      cmp($sformatf("ch2_s%0d_frame", n), f2, (n % 4 < 2) ? 1 : 0);
      if (n == 8) begin
        cmp("ch2_starve_uf", uf2, 1);
        cmp("ch2_starve_uf_cnt", cnt2, 1);
        vld2 = 2'b10; si2 = {12'h703, 12'h000}; sq2 = {12'h803, 12'h000};
      end
      if (n == 13) en2 = 1'b0;
    end
    tick();
    cmp("ch2_starve_idle_run", r2, 0);

    // 2T: reset in the middle of a frame
    vld2 = 2'b11; si2 = {12'h911, 12'h901}; sq2 = {12'h922, 12'h902};
    tick();
    tick();
    vld2 = 2'b00;
    en2 = 1'b1;
    wait_run2("ch2_rst_run_start");
    tick();
    rst2 = 1'b1;
    tick();
    cmp("ch2_rst_tx_d", d2, 0);
    cmp("ch2_rst_frame", f2, 0);
    cmp("ch2_rst_run", r2, 0);
    cmp("ch2_rst_ready", rdy2, 2'b00);
    cmp("ch2_rst_uf", uf2, 0);
    cmp("ch2_rst_uf_cnt", cnt2, 0);
    rst2 = 1'b0;
    tick();
    cmp("ch2_rst_release_ready", rdy2, 2'b11);
    for (int n = 0; n < 4; n++) begin
      tick();
      cmp($sformatf("ch2_rst_fifo_empty%0d", n), r2, 0);
    end
    en2 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_iq_framer.md
# tx_iq_framer

Parametrised transmit-side sample framer between the baseband modulators (Tx) and the AD9361 FDD interface. Buffers up to CH_NUM independent I/Q sample streams in per-channel FIFOs and emits them time-interleaved on a single DATA_W-bit bus with a frame marker, in the 1T or 2T single-port order the AD9361 TX port expects. It generalises the fixed 1T DAC_I/DAC_Q hookup to N channels, adds buffering, prefill and underflow handling, and runs entirely in the 32.768 MHz domain.

## Interface
- DATA_W, 12, sample width of I and Q.
- CH_NUM, 1, channel count (1 or 2).
- FIFO_DEPTH, 8, entries per channel FIFO (power of 2, ≥4).
- PREFILL, 2, minimum FIFO level per channel before streaming starts (1..FIFO_DEPTH).
- clk_32d768M  in  1  framer clock; all logic on its rising edge.
- rst_32d768M  in  1  reset, synchronous, active-high.
- enable  in  1  level; request streaming.
- s_valid  in  CH_NUM  per-channel sample valid.
- s_ready  out  CH_NUM  per-channel FIFO not full.
- s_i  in  CH_NUM*DATA_W  I samples, channel c at [c*DATA_W +: DATA_W].
- s_q  in  CH_NUM*DATA_W  Q samples, same packing.
- tx_d  out  DATA_W  interleaved output word.
- tx_frame  out  1  frame marker.
- tx_run  out  1  high while in RUN.
- underflow  out  1  sticky; set on any underflow frame, cleared by reset only.
- underflow_cnt  out  16  saturating count of underflow frames.

## Operation
- Per channel: write when s_valid[c] && s_ready[c]; s_ready[c] = !full[c]. Writes to full FIFO impossible by handshake.
- Frame = 2*CH_NUM cycles; slot counter k = 0..2*CH_NUM-1. Slot order: ch0 I, ch0 Q, ch1 I, ch1 Q.
- tx_frame: CH_NUM=1 → high on I slot, low on Q slot; CH_NUM=2 → high for both ch0 slots, low for both ch1 slots.
- States:
  - IDLE: tx_d=0, tx_frame=0, tx_run=0, no pops. Go PRIME when enable=1.
  - PRIME: wait until every FIFO level ≥ PREFILL, then RUN with k=0. enable=0 → IDLE.
  - RUN: at k=0 evaluate all channels: if all non-empty, pop one entry from every channel simultaneously and latch into frame registers; otherwise no pop on any channel (alignment preserved), frame registers loaded with zeros, underflow set, underflow_cnt += 1 (saturates at 0xFFFF). At k=last with enable=0 → IDLE (frame always completes).
- Channels never pop independently; FIFO levels differ only by upstream skew.
- Reset mid-operation: FIFOs emptied, state IDLE, counters cleared; next cycle outputs reset values.

## Timing
- Reset values: tx_d=0, tx_frame=0, tx_run=0, s_ready=all 1 (one cycle after reset release; 0 during reset), underflow=0, underflow_cnt=0.
- FIFO write → level visible to PRIME check the next cycle.
- Pop at k=0 (cycle T); registered outputs: tx_d/tx_frame for slot k appear at T+1+k. Output bus is continuous, no bubbles within or between frames in RUN.
- tx_run rises with first output word (T+1), falls the cycle after the last word of the final frame.
- Simultaneous write and pop on same FIFO in same cycle: both occur, level unchanged; allowed when full (s_ready still reflects pre-pop full).
- Underflow frame still drives tx_frame pattern normally, data zero.

## Configuration
- TX_FRAMER_PATTERN_EN: adds input pattern_sel (1 bit). When defined and pattern_sel=1 in RUN, frame registers load a DATA_W-bit ramp (I=ramp, Q=~ramp, all channels, ramp +1 per frame, wrapping) instead of FIFO data; FIFOs are not popped and no underflow is counted. Without the macro: port absent, FIFO data only.

## Structure
- Package tx_framer_pkg: state enum (IDLE, PRIME, RUN), DATA_W default, underflow counter width, slot-count function of CH_NUM.
- Sub-module sync_fifo (params DATA_W*2, FIFO_DEPTH; outputs full, empty, level), generated CH_NUM times; sequencer and output registers in top.

## Test plan
- CH_NUM=1, PREFILL=2: write (I,Q)=(0x123,0x456),(0x789,0xABC), enable → tx_d 0x123,0x456,0x789,0xABC, tx_frame 1,0,1,0, tx_run high from first word.
- CH_NUM=2: ch0 (0x111,0x222), ch1 (0x333,0x444) ×2 → 0x111,0x222,0x333,0x444 with tx_frame 1,1,0,0.
- Starve after 2 samples in RUN → third frame all zeros, underflow=1, underflow_cnt=1; refill → data resumes next frame, channels aligned.
- Fill FIFO_DEPTH=8 with enable=0 → s_ready=0 after 8 writes; 9th write dropped by handshake; enable → 8 samples out in order.
- Deassert enable at slot 1 of a CH_NUM=2 frame → remaining slots 2,3 emitted, then tx_d=0, tx_run=0; reset asserted mid-frame → all outputs at reset values next cycle.
- With TX_FRAMER_PATTERN_EN, pattern_sel=1 → I=0x000,0x001,…, Q=0xFFF,0xFFE,…, FIFO levels unchanged.
